// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a valid/ready holding register.
// Define UART_RX_SYNC_EN to pass rx_in through a 2-flop synchronizer (adds 2 cycles of latency).
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  // state | meaning
  // IDLE  | line idle, waiting for a low level
  // START | timing to the middle of the start bit to confirm it
  // DATA  | sampling data bits 0..7, LSB first
  // STOP  | timing to the stop bit sample
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'((H > 0) ? (H - 1) : 0);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_in};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_in;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_d;
  logic          valid_d, ferr_d, ovr_d;
  logic          tick;

  // cnt_q counts down the cycles remaining until the next sample point
  assign tick    = (cnt_q == '0);
  assign rx_busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = rx_data;
    valid_d = rx_valid & ~rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          bit_d = '0;
          if (H == 0) begin
            state_d = DATA;
            cnt_d   = BIT_LOAD;
          end else begin
            state_d = START;
            cnt_d   = HALF_LOAD;
          end
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = BIT_LOAD;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          if (rx_s) begin
            if (!rx_valid || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rx_data      <= data_d;
      rx_valid     <= valid_d;
      rx_frame_err <= ferr_d;
      rx_overrun   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: three receivers at CLKS_PER_BIT 1, 16 and 4 share one clock.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif
  localparam int EV_DAT = 1;
  localparam int EV_ERR = 2;
  localparam int EV_OVR = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx_in, rx_ready, rx_valid, rx_busy, rx_ferr, rx_ovr;
  logic [7:0] rx_data [3];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t_start [3] = '{0, 0, 0};
  int vrise [3] = '{0, 0, 0};
  int eq [3][$];
  string pn [$];
  int pa [$];
  int pe [$];
  logic [2:0] vprev = '0;
  logic [2:0] rprev = '0;
  logic [7:0] dprev [3] = '{8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rx_ready(rx_ready[0]), .rx_busy(rx_busy[0]), .rx_frame_err(rx_ferr[0]), .rx_overrun(rx_ovr[0]));
  uart_rx #(.CLKS_PER_BIT(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .rx_ready(rx_ready[1]), .rx_busy(rx_busy[1]), .rx_frame_err(rx_ferr[1]), .rx_overrun(rx_ovr[1]));
  uart_rx #(.CLKS_PER_BIT(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
    .rx_ready(rx_ready[2]), .rx_busy(rx_busy[2]), .rx_frame_err(rx_ferr[2]), .rx_overrun(rx_ovr[2]));

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int i, input int kind, input logic [7:0] d);
    int got;
    got = (kind << 8) | int'(d);
    if (eq[i].size() == 0) chk($sformatf("inst%0d_unexpected_event", i), got, 0);
    else chk($sformatf("inst%0d_event", i), got, eq[i].pop_front());
  endtask

  // monitor: pops the scoreboard on every DUT output event and drains stimulus probes
  always @(negedge clk) begin
    while (pn.size() > 0) chk(pn.pop_front(), pa.pop_front(), pe.pop_front());
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        chk($sformatf("inst%0d_rst_valid", i), int'(rx_valid[i]), 0);
        chk($sformatf("inst%0d_rst_busy", i), int'(rx_busy[i]), 0);
        chk($sformatf("inst%0d_rst_data", i), int'(rx_data[i]), 0);
        chk($sformatf("inst%0d_rst_pulses", i), int'({rx_ferr[i], rx_ovr[i]}), 0);
      end else begin
        if (rx_ferr[i] || rx_ovr[i])
          chk($sformatf("inst%0d_err_ovr_exclusive", i), int'(rx_ferr[i] & rx_ovr[i]), 0);
        if (rx_ferr[i]) expect_ev(i, EV_ERR, 8'h00);
        if (rx_ovr[i]) expect_ev(i, EV_OVR, 8'h00);
        if (rx_valid[i] && rx_ready[i]) expect_ev(i, EV_DAT, rx_data[i]);
        if (rx_valid[i] && !vprev[i]) vrise[i] = cyc;
        if (vprev[i] && !rprev[i] && rx_valid[i])
          chk($sformatf("inst%0d_hold_data", i), int'(rx_data[i]), int'(dprev[i]));
      end
      vprev[i] = rx_valid[i];
      rprev[i] = rx_ready[i];
      dprev[i] = rx_data[i];
    end
  end

  task automatic probe(input string nm, input int act, input int exp);
    pn.push_back(nm);
    pa.push_back(act);
    pe.push_back(exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [9:0] mk(input logic [7:0] b, input logic stop);
    return {stop, b, 1'b0};
  endfunction

  // drives the first nb bits of a frame, C cycles each; called 1 time unit after a rising edge
  task automatic send(input int i, input int c, input logic [9:0] fr, input int nb);
    t_start[i] = cyc + 1;
    for (int k = 0; k < nb; k++) begin
      rx_in[i] = fr[k];
      wait_cyc(c);
    end
    rx_in[i] = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_in    = 3'b111;
    rx_ready = 3'b111;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2 + SD);

    // single byte 8'h55, consumer always ready
    eq[0].push_back((EV_DAT << 8) | 'h55);
    send(0, 1, mk(8'h55, 1'b1), 10);
    wait_cyc(SD);
    probe("t1_valid", int'(rx_valid[0]), 1);
    probe("t1_data", int'(rx_data[0]), 'h55);
    wait_cyc(1);
    probe("t1_valid_one_cycle", int'(rx_valid[0]), 0);
    probe("t1_latency", vrise[0] - t_start[0] + 1, 10 + SD);
    wait_cyc(3);

    // back-to-back frames with consumer stalled -> overrun on the second
    rx_ready[0] = 1'b0;
    eq[0].push_back(EV_OVR << 8);
    eq[0].push_back((EV_DAT << 8) | 'hA5);
    send(0, 1, mk(8'hA5, 1'b1), 10);
    send(0, 1, mk(8'h3C, 1'b1), 10);
    wait_cyc(SD);
    probe("t2_overrun", int'(rx_ovr[0]), 1);
    probe("t2_held_data", int'(rx_data[0]), 'hA5);
    probe("t2_held_valid", int'(rx_valid[0]), 1);
    wait_cyc(1);
    probe("t2_overrun_pulse", int'(rx_ovr[0]), 0);
    wait_cyc(4);
    probe("t2_still_held", int'(rx_data[0]), 'hA5);
    rx_ready[0] = 1'b1;
    wait_cyc(3);
    probe("t2_drained", int'(rx_valid[0]), 0);

    // bad stop bit, then a good frame
    eq[0].push_back(EV_ERR << 8);
    eq[0].push_back((EV_DAT << 8) | 'h12);
    send(0, 1, mk(8'hFF, 1'b0), 10);
    wait_cyc(SD);
    probe("t3_frame_err", int'(rx_ferr[0]), 1);
    probe("t3_no_valid", int'(rx_valid[0]), 0);
    wait_cyc(1);
    probe("t3_frame_err_pulse", int'(rx_ferr[0]), 0);
    send(0, 1, mk(8'h12, 1'b1), 10);
    wait_cyc(SD + 2);
    probe("t3_latency", vrise[0] - t_start[0] + 1, 10 + SD);
    probe("t3_data", int'(rx_data[0]), 'h12);

    // C=16: one-cycle glitch is rejected at the start-bit midpoint, then a full frame
    rx_in[1] = 1'b0;
    wait_cyc(1);
    rx_in[1] = 1'b1;
    wait_cyc(2 + SD);
    probe("t4_busy_early", int'(rx_busy[1]), 1);
    wait_cyc(4);
    probe("t4_busy_before_sample", int'(rx_busy[1]), 1);
    wait_cyc(2);
    probe("t4_busy_dropped", int'(rx_busy[1]), 0);
    eq[1].push_back((EV_DAT << 8) | 'hC3);
    send(1, 16, mk(8'hC3, 1'b1), 10);
    wait_cyc(2 + SD);
    probe("t4_latency", vrise[1] - t_start[1] + 1, 152 + SD);
    probe("t4_data", int'(rx_data[1]), 'hC3);

    // C=4: reset during data bit 3 of 8'h81, then 8'h7E
    send(2, 4, mk(8'h81, 1'b1), 4);
    rx_in[2] = 1'b0;
    wait_cyc(2);
    probe("t5_busy_mid_frame", int'(rx_busy[2]), 1);
    rst_n = 1'b0;
    #1;
    probe("t5_rst_busy", int'(rx_busy[2]), 0);
    probe("t5_rst_data_c1", int'(rx_data[0]), 0);
    probe("t5_rst_data_c16", int'(rx_data[1]), 0);
    rx_in[2] = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2 + SD);
    eq[2].push_back((EV_DAT << 8) | 'h7E);
    send(2, 4, mk(8'h7E, 1'b1), 10);
    wait_cyc(2 + SD);
    probe("t5_latency", vrise[2] - t_start[2] + 1, 38 + SD);
    probe("t5_data", int'(rx_data[2]), 'h7E);

    // transfer and new load on the same edge
    rx_ready[0] = 1'b0;
    eq[0].push_back((EV_DAT << 8) | 'h11);
    eq[0].push_back((EV_DAT << 8) | 'h99);
    send(0, 1, mk(8'h11, 1'b1), 10);
    send(0, 1, mk(8'h99, 1'b1), 9);
    wait_cyc(SD);
    rx_ready[0] = 1'b1;
    wait_cyc(1);
    rx_ready[0] = 1'b0;
    probe("t6_valid_kept", int'(rx_valid[0]), 1);
    probe("t6_new_data", int'(rx_data[0]), 'h99);
    probe("t6_no_overrun", int'(rx_ovr[0]), 0);
    wait_cyc(2);
    rx_ready[0] = 1'b1;
    wait_cyc(5);

    for (int i = 0; i < 3; i++) probe($sformatf("inst%0d_scoreboard_empty", i), eq[i].size(), 0);
    wait_cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
